seq_shift_add_mult: RTL and testbench
=====================================

Name: seq_shift_add_mult

Overview:
- Parametrised iterative unsigned multiplier; successor to the team's fixed 2x2 combinational partial-product multipliers.
- Accepts one operand pair per valid/ready handshake and accumulates one partial product per cycle, radix-2 by default.
- Returns the full-width product through a valid/ready output with backpressure.
- Used as the sequential baseline in the multiplier design-space exploration flow.

Parameters:
- A_W, 8, width of operand a (>=2)
- B_W, 8, width of operand b (>=2)
- P_W, A_W+B_W, product width (derived; not overridable)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- a  input  A_W  multiplicand, unsigned
- b  input  B_W  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- p  output  P_W  product a*b
- busy  output  1  high in BUSY state

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, p=0, busy=0, internal regs=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register a and b, clear accumulator, set cnt=0, go to BUSY.
- BUSY: in_ready=0. Each cycle add (a_reg * digit) << (cnt*STEP) into the P_W accumulator, where digit is the current STEP-bit slice of b_reg; then increment cnt.
  - Radix-2: STEP=1, ITER=B_W.
  - After ITER adds, go to DONE.
- DONE: out_valid=1, p=accumulator. p is held stable while out_ready=0.
  - On out_ready: out_valid drops next cycle.
- Back-to-back: in_ready=(state==IDLE)||(state==DONE&&out_ready).
  - A new accept in DONE with out_ready goes directly to BUSY.
  - out_valid deasserts on that same edge.
- Latency: operands accepted at edge N give out_valid=1 after edge N+ITER. Latency is fixed and independent of operand values; there is no zero shortcut.
- Width rules: all accumulation is P_W wide and cannot overflow, since max (2^A_W-1)(2^B_W-1) < 2^P_W. cnt width is clog2(ITER+1).
- Inputs a and b are ignored whenever in_ready=0.
- Reset asserted mid-operation aborts immediately to reset values. No partial result is emitted.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro: SEQ_MULT_RADIX4_EN.
- Defined: STEP=2, ITER=ceil(B_W/2).
  - Digit 0..3 selects 0, A, 2A or 3A.
  - 3A is precomputed once at accept into a register A_W+2 bits wide.
  - An odd B_W is zero-extended by one bit.
  - Latency becomes ITER cycles; all handshake rules are unchanged.
- Undefined: radix-2 as above, and no 3A register is instantiated.

Decomposition:
- Package seq_mult_pkg holds:
  - state enum (IDLE, BUSY, DONE);
  - function iter_count(b_w, radix4) returning ITER;
  - function clog2.
- Sub-module mult_pp_sel: combinational, maps digit plus a_reg (and 3A) to an aligned partial product. It is instantiated once.

Test Plan:
- A_W=B_W=8, a=255, b=255, out_ready=1 -> p=65025, out_valid 8 cycles after accept (4 with SEQ_MULT_RADIX4_EN).
- A_W=B_W=2, exhaustive 16 pairs -> p=a*b for each, e.g. 3*3=9 and 2*1=2; results match the combinational 2x2 golden model.
- a=13, b=11, out_ready held low 5 cycles after out_valid -> p=143 stable, in_ready=0, out_valid held; releases on out_ready.
- Back-to-back: pairs (7,6) then (0,200) with in_valid and out_ready tied high -> p=42 then p=0; the second accept coincides with the first result's handshake; no idle cycle.
- rst_n pulsed low at cycle 3 of BUSY (a=100, b=100) -> out_valid=0, p=0, in_ready=1 immediately; a following (9,9) yields 81.
- A_W=5, B_W=7 with the radix-4 build, a=31, b=127 -> p=3937 after 4 cycles (odd B_W padding).

Source files
------------

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: FSM state type and elaboration-time sizing helpers shared by
// seq_shift_add_mult and mult_pp_sel.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

   // Number of partial-product cycles needed to cover b_w multiplier bits.
   function automatic int iter_count(input int b_w, input bit radix4);
      return radix4 ? (b_w + 1) / 2 : b_w;
   endfunction

endpackage

// File: rtl/mult_pp_sel.sv
// mult_pp_sel: maps the current multiplier digit and the multiplicand to the
// partial product aligned to its digit position. SEQ_MULT_RADIX4_EN selects 2-bit digits.
module mult_pp_sel #(
   parameter int A_W   = 8,
   parameter int P_W   = 16,
   parameter int STEP  = 1,
   parameter int CNT_W = 4
) (
   input  logic [STEP-1:0]  i_digit,
   input  logic [A_W-1:0]   i_a,
`ifdef SEQ_MULT_RADIX4_EN
   input  logic [A_W+1:0]   i_a3,
`endif
   input  logic [CNT_W-1:0] i_cnt,
   output logic [P_W-1:0]   o_pp
);

`ifdef SEQ_MULT_RADIX4_EN
   logic [A_W+1:0] w_mag;

   // Digit value 0..3 selects 0, A, 2A or the precomputed 3A.
   always_comb begin
      w_mag = '0;
      case (i_digit)
         2'd0:    w_mag = '0;
         2'd1:    w_mag = {2'b00, i_a};
         2'd2:    w_mag = {1'b0, i_a, 1'b0};
         2'd3:    w_mag = i_a3;
         default: w_mag = '0;
      endcase
   end
`else
   logic [A_W-1:0] w_mag;

   // Single-bit digit gates the multiplicand.
   always_comb begin
      w_mag = '0;
      if (i_digit[0]) begin
         w_mag = i_a;
      end else begin
         w_mag = '0;
      end
   end
`endif

   assign o_pp = P_W'(w_mag) << (int'(i_cnt) * STEP);

endmodule

// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: iterative unsigned shift-add multiplier with valid/ready in and out.
// Define SEQ_MULT_RADIX4_EN to retire two multiplier bits per cycle instead of one.
module seq_shift_add_mult
   import seq_mult_pkg::*;
#(
   parameter int  A_W = 8,
   parameter int  B_W = 8,
   localparam int P_W = A_W + B_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [P_W-1:0] p,
   output logic           busy
);

`ifdef SEQ_MULT_RADIX4_EN
   localparam int STEP   = 2;
   localparam bit RADIX4 = 1'b1;
`else
   localparam int STEP   = 1;
   localparam bit RADIX4 = 1'b0;
`endif
   localparam int ITER  = iter_count(B_W, RADIX4);
   localparam int CNT_W = clog2(ITER + 1);
   // An odd B_W is zero-padded up to a whole number of digits.
   localparam int BP_W  = ITER * STEP;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

   state_t           r_state;
   logic [A_W-1:0]   r_a;
   logic [BP_W-1:0]  r_b;
   logic [P_W-1:0]   r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_out_valid;
   logic             r_busy;
   logic             w_in_ready;
   logic             w_accept;
   logic [P_W-1:0]   w_pp;
`ifdef SEQ_MULT_RADIX4_EN
   logic [A_W+1:0]   r_a3;
`endif

   // DONE with out_ready frees the unit on the same edge, so a new pair can enter without a gap.
   assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
   assign w_accept   = in_valid && w_in_ready;

   mult_pp_sel #(
      .A_W   (A_W),
      .P_W   (P_W),
      .STEP  (STEP),
      .CNT_W (CNT_W)
   ) u_pp_sel (
      .i_digit (r_b[STEP-1:0]),
      .i_a     (r_a),
`ifdef SEQ_MULT_RADIX4_EN
      .i_a3    (r_a3),
`endif
      .i_cnt   (r_cnt),
      .o_pp    (w_pp)
   );

   // Control FSM and datapath registers; r_b shifts so the active digit is always in the LSBs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
`ifdef SEQ_MULT_RADIX4_EN
         r_a3        <= '0;
`endif
      end else if (w_accept) begin
         r_state     <= BUSY;
         r_a         <= a;
         r_b         <= BP_W'(b);
         r_acc       <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b1;
`ifdef SEQ_MULT_RADIX4_EN
         r_a3        <= {2'b00, a} + {1'b0, a, 1'b0};
`endif
      end else begin
         case (r_state)
            BUSY: begin
               r_acc <= r_acc + w_pp;
               r_b   <= r_b >> STEP;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_CNT) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign p         = r_acc;
   assign busy      = r_busy;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb_seq_shift_add_mult: directed checks of seq_shift_add_mult in 8x8, 2x2 and 5x7 configurations.
// Expected latencies follow SEQ_MULT_RADIX4_EN.
module tb_seq_shift_add_mult;

`ifdef SEQ_MULT_RADIX4_EN
   localparam int ITER8  = 4;
   localparam int ITER2  = 1;
   localparam int ITER57 = 4;
   localparam int P_MID  = 3600;
`else
   localparam int ITER8  = 8;
   localparam int ITER2  = 2;
   localparam int ITER57 = 7;
   localparam int P_MID  = 400;
`endif
   localparam int TMO = 64;

   logic        clk;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [7:0]  a, b;
   logic [15:0] p;
   logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
   logic [1:0]  a2, b2;
   logic [3:0]  p2;
   logic        in_valid57, in_ready57, out_valid57, out_ready57, busy57;
   logic [4:0]  a57;
   logic [6:0]  b57;
   logic [11:0] p57;
   int          n_checks;
   int          n_pass;

   seq_shift_add_mult #(.A_W(8), .B_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy));

   seq_shift_add_mult #(.A_W(2), .B_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
      .out_valid(out_valid2), .out_ready(out_ready2), .p(p2), .busy(busy2));

   seq_shift_add_mult #(.A_W(5), .B_W(7)) u_dut57 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid57), .in_ready(in_ready57), .a(a57), .b(b57),
      .out_valid(out_valid57), .out_ready(out_ready57), .p(p57), .busy(busy57));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: the old combinational 2x2 partial-product multiplier.
   function automatic logic [3:0] golden2x2(input logic [1:0] x, input logic [1:0] y);
      logic [3:0] pp0, pp1;
      pp0 = {2'b00, x & {2{y[0]}}};
      pp1 = {1'b0, x & {2{y[1]}}, 1'b0};
      return pp0 + pp1;
   endfunction

   task automatic run8(input logic [7:0] ia, input logic [7:0] ib, output int lat);
      @(negedge clk);
      a = ia; b = ib; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < TMO) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1; a = 8'd0; b = 8'd0;
      in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = 2'd0; b2 = 2'd0;
      in_valid57 = 1'b0; out_ready57 = 1'b1; a57 = 5'd0; b57 = 7'd0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
      else n_pass++;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", out_valid);
      else n_pass++;
      n_checks++;
      if (p !== 16'd0) $display("FAIL reset_p: got %0d expected 0", p);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy);
      else n_pass++;
      rst_n = 1'b1;
   endtask

   task automatic test_max();
      int lat;
      out_ready = 1'b1;
      run8(8'd255, 8'd255, lat);
      n_checks++;
      if (lat !== ITER8) $display("FAIL max_latency: got %0d expected %0d", lat, ITER8);
      else n_pass++;
      n_checks++;
      if (p !== 16'd65025) $display("FAIL max_p: got %0d expected 65025", p);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL max_valid_drop: got %0b expected 0", out_valid);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL max_idle_ready: got %0b expected 1", in_ready);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int lat;
      out_ready = 1'b0;
      run8(8'd13, 8'd11, lat);
      n_checks++;
      if (p !== 16'd143) $display("FAIL bp_p: got %0d expected 143", p);
      else n_pass++;
      // Operands offered during the hold must be ignored.
      in_valid = 1'b1; a = 8'd99; b = 8'd99;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (p !== 16'd143) $display("FAIL bp_hold_p: got %0d expected 143", p);
         else n_pass++;
         n_checks++;
         if (out_valid !== 1'b1) $display("FAIL bp_hold_valid: got %0b expected 1", out_valid);
         else n_pass++;
         n_checks++;
         if (in_ready !== 1'b0) $display("FAIL bp_hold_in_ready: got %0b expected 0", in_ready);
         else n_pass++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %0b expected 1", in_ready);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %0b expected 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lat;
      out_ready = 1'b1;
      @(negedge clk);
      a = 8'd7; b = 8'd6; in_valid = 1'b1;
      @(negedge clk);
      a = 8'd0; b = 8'd200;
      lat = 0;
      while (out_valid !== 1'b1 && lat < TMO) begin
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (lat !== ITER8) $display("FAIL b2b_lat1: got %0d expected %0d", lat, ITER8);
      else n_pass++;
      n_checks++;
      if (p !== 16'd42) $display("FAIL b2b_p1: got %0d expected 42", p);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL b2b_done_ready: got %0b expected 1", in_ready);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL b2b_valid_drop: got %0b expected 0", out_valid);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL b2b_no_idle: got %0b expected 1", busy);
      else n_pass++;
      lat = 0;
      while (out_valid !== 1'b1 && lat < TMO) begin
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (lat !== ITER8) $display("FAIL b2b_lat2: got %0d expected %0d", lat, ITER8);
      else n_pass++;
      n_checks++;
      if (p !== 16'd0) $display("FAIL b2b_p2: got %0d expected 0", p);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat;
      out_ready = 1'b1;
      @(negedge clk);
      a = 8'd100; b = 8'd100; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (p !== 16'(P_MID)) $display("FAIL mid_partial: got %0d expected %0d", p, P_MID);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %0b expected 0", out_valid);
      else n_pass++;
      n_checks++;
      if (p !== 16'd0) $display("FAIL mid_rst_p: got %0d expected 0", p);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL mid_rst_ready: got %0b expected 1", in_ready);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %0b expected 0", busy);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      run8(8'd9, 8'd9, lat);
      n_checks++;
      if (p !== 16'd81) $display("FAIL mid_after_p: got %0d expected 81", p);
      else n_pass++;
      n_checks++;
      if (lat !== ITER8) $display("FAIL mid_after_lat: got %0d expected %0d", lat, ITER8);
      else n_pass++;
   endtask

   task automatic test_exhaustive_2x2();
      int         lat;
      logic [3:0] exp_p;
      out_ready2 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            a2 = i[1:0]; b2 = j[1:0]; in_valid2 = 1'b1;
            @(negedge clk);
            in_valid2 = 1'b0;
            lat = 0;
            while (out_valid2 !== 1'b1 && lat < TMO) begin
               @(negedge clk);
               lat++;
            end
            exp_p = golden2x2(i[1:0], j[1:0]);
            n_checks++;
            if (p2 !== exp_p) $display("FAIL x2_p a=%0d b=%0d: got %0d expected %0d", i, j, p2, exp_p);
            else n_pass++;
            n_checks++;
            if (lat !== ITER2) $display("FAIL x2_lat a=%0d b=%0d: got %0d expected %0d", i, j, lat, ITER2);
            else n_pass++;
            if (i == 3 && j == 3) begin
               n_checks++;
               if (p2 !== 4'd9) $display("FAIL x2_3x3: got %0d expected 9", p2);
               else n_pass++;
            end
            if (i == 2 && j == 1) begin
               n_checks++;
               if (p2 !== 4'd2) $display("FAIL x2_2x1: got %0d expected 2", p2);
               else n_pass++;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_odd_width();
      int lat;
      out_ready57 = 1'b1;
      @(negedge clk);
      a57 = 5'd31; b57 = 7'd127; in_valid57 = 1'b1;
      @(negedge clk);
      in_valid57 = 1'b0;
      lat = 0;
      while (out_valid57 !== 1'b1 && lat < TMO) begin
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (p57 !== 12'd3937) $display("FAIL odd_p: got %0d expected 3937", p57);
      else n_pass++;
      n_checks++;
      if (lat !== ITER57) $display("FAIL odd_lat: got %0d expected %0d", lat, ITER57);
      else n_pass++;
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_max();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_exhaustive_2x2();
      test_odd_width();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
